// File: rtl/spi_master_parallel.sv
// rtl/spi_master_parallel.sv - parallel-word SPI-style master with burst, stall and abort handling
module spi_master_parallel #(
    parameter int NB_BITS = 32,
    parameter int NB_CS   = 4,
    parameter int CLK_DIV = 4,
    parameter int NB_LEN  = 6
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [$clog2(NB_CS)-1:0] i_cs_sel,
    input  logic [NB_LEN-1:0]        i_len,
    input  logic                     i_abort,
    input  logic [NB_BITS-1:0]       i_tx_data,
    input  logic                     i_tx_valid,
    output logic                     o_tx_ready,
    output logic [NB_BITS-1:0]       o_rx_data,
    output logic                     o_rx_valid,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [NB_BITS-1:0]       o_MOSI,
    output logic                     o_SCLK,
    output logic [NB_CS-1:0]         o_cs,
    input  logic [NB_BITS-1:0]       i_MISO
);

    localparam int SEL_W = $clog2(NB_CS);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_HIGH,
        ST_TAIL
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DIV_W-1:0]  div_cnt;
    logic [NB_LEN-1:0] rem_cnt;
    logic [SEL_W-1:0]  sel_q;
    logic              div_last;
    logic              tx_hs;
    logic              capture;
    logic              tail_exit;
    logic              tail_exit_q;

    assign div_last  = (div_cnt == DIV_LAST);
    assign tx_hs     = (state == ST_LOAD) && i_tx_valid;
    assign capture   = (state == ST_HIGH) && div_last;
    assign tail_exit = (state == ST_TAIL) && div_last;

    assign o_busy     = (state != ST_IDLE);
    assign o_tx_ready = (state == ST_LOAD);
    assign o_SCLK     = (state == ST_HIGH);

    // State register; reset lands in IDLE so CS and SCLK drop without a clock edge
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort wins everywhere except the capture cycle, where the word completes
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (i_abort)         state_nxt = ST_TAIL;
                else if (i_tx_valid) state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                if (i_abort)       state_nxt = ST_TAIL;
                else if (div_last) state_nxt = ST_HIGH;
            end
            ST_HIGH: begin
                if (div_last) begin
                    if (i_abort || (rem_cnt == NB_LEN'(1))) state_nxt = ST_TAIL;
                    else                                     state_nxt = ST_LOAD;
                end else if (i_abort) begin
                    state_nxt = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (div_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Half-period timer: restarts on every state change, counts only in timed states
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            div_cnt <= '0;
        end else if (state_nxt != state) begin
            div_cnt <= '0;
        end else if ((state == ST_SETUP) || (state == ST_HIGH) || (state == ST_TAIL)) begin
            div_cnt <= div_cnt + DIV_W'(1);
        end else begin
            div_cnt <= '0;
        end
    end

    // Burst bookkeeping, data path and pulses; o_done follows the CS release by one cycle
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sel_q       <= '0;
            rem_cnt     <= '0;
            o_MOSI      <= '0;
            o_rx_data   <= '0;
            o_rx_valid  <= 1'b0;
            tail_exit_q <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_rx_valid  <= capture;
            tail_exit_q <= tail_exit;
            o_done      <= tail_exit_q;
            if ((state == ST_IDLE) && i_start) begin
                sel_q   <= i_cs_sel;
                rem_cnt <= (i_len == '0) ? NB_LEN'(1) : i_len;
            end
            if (tx_hs) begin
                o_MOSI <= i_tx_data;
            end else if (tail_exit) begin
                o_MOSI <= '0;
            end
            if (capture) begin
                o_rx_data <= i_MISO;
                rem_cnt   <= rem_cnt - NB_LEN'(1);
            end
        end
    end

    // Chip-select decode: the latched slave is low for the whole burst including TAIL
    always_comb begin
        o_cs = '1;
        if (state != ST_IDLE) o_cs[sel_q] = 1'b0;
    end

endmodule

// File: tb/tb_spi_master_parallel.sv
// tb/tb_spi_master_parallel.sv - directed self-checking bench for spi_master_parallel
module tb_spi_master_parallel;

    localparam int NB_BITS = 32;
    localparam int NB_CS   = 4;
    localparam int CLK_DIV = 4;
    localparam int NB_LEN  = 6;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_start;
    logic [1:0]         i_cs_sel;
    logic [NB_LEN-1:0]  i_len;
    logic               i_abort;
    logic [NB_BITS-1:0] i_tx_data;
    logic               i_tx_valid;
    logic               o_tx_ready;
    logic [NB_BITS-1:0] o_rx_data;
    logic               o_rx_valid;
    logic               o_busy;
    logic               o_done;
    logic [NB_BITS-1:0] o_MOSI;
    logic               o_SCLK;
    logic [NB_CS-1:0]   o_cs;
    logic [NB_BITS-1:0] i_MISO;

    logic               miso_inv;
    logic [NB_BITS-1:0] miso_const;
    logic [NB_CS-1:0]   exp_cs;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int rxv_cnt = 0;
    int done_cnt = 0;
    int hs_cnt = 0;
    int sclk_rise_cnt = 0;
    int cs_err_cnt = 0;
    int gap_bad_cnt = 0;
    int last_rxv_cyc = 0;
    int last_done_cyc = 0;
    int last_hs_cyc = 0;
    bit rxv_seen = 1'b0;
    bit sclk_prev = 1'b0;

    assign i_MISO = miso_inv ? ~o_MOSI : miso_const;

    spi_master_parallel #(
        .NB_BITS(NB_BITS),
        .NB_CS  (NB_CS),
        .CLK_DIV(CLK_DIV),
        .NB_LEN (NB_LEN)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_cs_sel  (i_cs_sel),
        .i_len     (i_len),
        .i_abort   (i_abort),
        .i_tx_data (i_tx_data),
        .i_tx_valid(i_tx_valid),
        .o_tx_ready(o_tx_ready),
        .o_rx_data (o_rx_data),
        .o_rx_valid(o_rx_valid),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_MOSI    (o_MOSI),
        .o_SCLK    (o_SCLK),
        .o_cs      (o_cs),
        .i_MISO    (i_MISO)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Event monitor sampled on the falling edge
    always @(negedge i_clk) begin
        sclk_prev <= o_SCLK;
        if (o_SCLK && !sclk_prev) sclk_rise_cnt <= sclk_rise_cnt + 1;
        if (o_tx_ready && i_tx_valid) begin
            hs_cnt      <= hs_cnt + 1;
            last_hs_cyc <= cyc;
        end
        if (o_rx_valid) begin
            rxv_cnt      <= rxv_cnt + 1;
            last_rxv_cyc <= cyc;
            rxv_seen     <= 1'b1;
            if (rxv_seen && (cyc - last_rxv_cyc != 2 * CLK_DIV + 1)) gap_bad_cnt <= gap_bad_cnt + 1;
        end
        if (o_done) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
            rxv_seen      <= 1'b0;
        end
        if (o_busy ? (o_cs !== exp_cs) : (o_cs !== 4'hF)) cs_err_cnt <= cs_err_cnt + 1;
    end

    task automatic wait_done(input int d0, input int budget, output bit ok);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge i_clk);
            n++;
        end
        ok = (done_cnt != d0);
        #1;
    endtask

    task automatic wait_rxv(input int target, input int budget, output bit ok);
        int n;
        n = 0;
        while (rxv_cnt < target && n < budget) begin
            @(posedge i_clk);
            n++;
        end
        ok = (rxv_cnt >= target);
    endtask

    task automatic wait_hs(input int target, input int budget, output bit ok);
        int n;
        n = 0;
        while (hs_cnt < target && n < budget) begin
            @(posedge i_clk);
            n++;
        end
        ok = (hs_cnt >= target);
    endtask

    task automatic test_reset;
        i_rst = 1'b0; i_start = 1'b0; i_cs_sel = '0; i_len = '0; i_abort = 1'b0;
        i_tx_data = '0; i_tx_valid = 1'b0; miso_inv = 1'b0; miso_const = '0; exp_cs = 4'hF;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        checks++; if (o_cs !== 4'hF)    begin errors++; $display("FAIL reset_cs: got %b exp 1111", o_cs); end
        checks++; if (o_SCLK !== 1'b0)  begin errors++; $display("FAIL reset_sclk: got %b exp 0", o_SCLK); end
        checks++; if (o_MOSI !== '0)    begin errors++; $display("FAIL reset_mosi: got %h exp 0", o_MOSI); end
        checks++; if (o_rx_data !== '0) begin errors++; $display("FAIL reset_rx_data: got %h exp 0", o_rx_data); end
        checks++; if (o_rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b exp 0", o_rx_valid); end
        checks++; if (o_done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b exp 0", o_done); end
        checks++; if (o_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b exp 0", o_busy); end
        checks++; if (o_tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready: got %b exp 0", o_tx_ready); end
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_single_word;
        int h0;
        logic             e_sclk, e_busy, e_rxv, e_done;
        logic [NB_CS-1:0] e_cs;
        h0 = hs_cnt;
        exp_cs = 4'b1011; miso_inv = 1'b0; miso_const = 32'h1234_5678;
        i_cs_sel = 2'd2; i_len = 6'd1; i_tx_data = 32'hDEAD_BEEF; i_tx_valid = 1'b1; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge i_clk);
            e_sclk = (k >= 5 && k <= 8);
            e_busy = (k <= 12);
            e_rxv  = (k == 9);
            e_done = (k == 14);
            e_cs   = (k <= 12) ? 4'b1011 : 4'hF;
            checks++; if (o_SCLK !== e_sclk) begin errors++; $display("FAIL single_sclk k=%0d: got %b exp %b", k, o_SCLK, e_sclk); end
            checks++; if (o_busy !== e_busy) begin errors++; $display("FAIL single_busy k=%0d: got %b exp %b", k, o_busy, e_busy); end
            checks++; if (o_rx_valid !== e_rxv) begin errors++; $display("FAIL single_rx_valid k=%0d: got %b exp %b", k, o_rx_valid, e_rxv); end
            checks++; if (o_done !== e_done) begin errors++; $display("FAIL single_done k=%0d: got %b exp %b", k, o_done, e_done); end
            checks++; if (o_cs !== e_cs) begin errors++; $display("FAIL single_cs k=%0d: got %b exp %b", k, o_cs, e_cs); end
            if (k == 0) begin
                checks++; if (o_tx_ready !== 1'b1) begin errors++; $display("FAIL single_tx_ready: got %b exp 1", o_tx_ready); end
            end
            if (k >= 1 && k <= 8) begin
                checks++; if (o_MOSI !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_mosi k=%0d: got %h exp deadbeef", k, o_MOSI); end
            end
            if (k == 9) begin
                checks++; if (o_rx_data !== 32'h1234_5678) begin errors++; $display("FAIL single_rx_data: got %h exp 12345678", o_rx_data); end
            end
            if (k == 13) begin
                checks++; if (o_MOSI !== '0) begin errors++; $display("FAIL single_mosi_idle: got %h exp 0", o_MOSI); end
            end
        end
        checks++; if (hs_cnt - h0 !== 1) begin errors++; $display("FAIL single_handshakes: got %0d exp 1", hs_cnt - h0); end
        i_tx_valid = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_burst;
        int r0, d0, g0, c0, s0;
        bit ok;
        r0 = rxv_cnt; d0 = done_cnt; g0 = gap_bad_cnt; c0 = cs_err_cnt; s0 = sclk_rise_cnt;
        exp_cs = 4'b1110; miso_inv = 1'b1;
        i_cs_sel = 2'd0; i_len = 6'd32; i_tx_data = 32'hA5A5_0F0F; i_tx_valid = 1'b1; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        wait_done(d0, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_timeout: o_done not seen within 400 cycles"); end
        checks++; if (rxv_cnt - r0 !== 32) begin errors++; $display("FAIL burst_rx_count: got %0d exp 32", rxv_cnt - r0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL burst_done_count: got %0d exp 1", done_cnt - d0); end
        checks++; if (gap_bad_cnt - g0 !== 0) begin errors++; $display("FAIL burst_rx_spacing: got %0d bad gaps exp 0", gap_bad_cnt - g0); end
        checks++; if (cs_err_cnt - c0 !== 0) begin errors++; $display("FAIL burst_cs: got %0d bad cycles exp 0", cs_err_cnt - c0); end
        checks++; if (sclk_rise_cnt - s0 !== 32) begin errors++; $display("FAIL burst_sclk_strobes: got %0d exp 32", sclk_rise_cnt - s0); end
        checks++; if (o_rx_data !== 32'h5A5A_F0F0) begin errors++; $display("FAIL burst_rx_data: got %h exp 5a5af0f0", o_rx_data); end
        i_tx_valid = 1'b0;
    endtask

    task automatic test_stall;
        int r0, d0, c0, s0, h0, n;
        bit ok;
        r0 = rxv_cnt; d0 = done_cnt; c0 = cs_err_cnt; s0 = sclk_rise_cnt; h0 = hs_cnt;
        exp_cs = 4'b0111; miso_inv = 1'b1;
        i_cs_sel = 2'd3; i_len = 6'd3; i_tx_data = 32'h1111_2222; i_tx_valid = 1'b1; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        wait_hs(h0 + 1, 20, ok);
        #1;
        i_tx_valid = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL stall_first_handshake: not seen within 20 cycles"); end
        n = 0;
        @(negedge i_clk);
        while (!o_tx_ready && n < 30) begin
            @(negedge i_clk);
            n++;
        end
        checks++; if (o_tx_ready !== 1'b1) begin errors++; $display("FAIL stall_reach_load: tx_ready got %b exp 1", o_tx_ready); end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge i_clk);
            checks++; if (o_SCLK !== 1'b0) begin errors++; $display("FAIL stall_sclk i=%0d: got %b exp 0", i, o_SCLK); end
            checks++; if (o_tx_ready !== 1'b1) begin errors++; $display("FAIL stall_hold_load i=%0d: got %b exp 1", i, o_tx_ready); end
        end
        @(posedge i_clk); #1;
        i_tx_data = 32'h3333_4444; i_tx_valid = 1'b1;
        wait_done(d0, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: o_done not seen within 100 cycles"); end
        checks++; if (rxv_cnt - r0 !== 3) begin errors++; $display("FAIL stall_rx_count: got %0d exp 3", rxv_cnt - r0); end
        checks++; if (sclk_rise_cnt - s0 !== 3) begin errors++; $display("FAIL stall_sclk_strobes: got %0d exp 3", sclk_rise_cnt - s0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL stall_done_count: got %0d exp 1", done_cnt - d0); end
        checks++; if (cs_err_cnt - c0 !== 0) begin errors++; $display("FAIL stall_cs: got %0d bad cycles exp 0", cs_err_cnt - c0); end
        checks++; if (o_rx_data !== 32'hCCCC_BBBB) begin errors++; $display("FAIL stall_rx_data: got %h exp ccccbbbb", o_rx_data); end
        i_tx_valid = 1'b0;
    endtask

    task automatic test_abort;
        int r0, d0, c0;
        bit ok;
        r0 = rxv_cnt; d0 = done_cnt; c0 = cs_err_cnt;
        exp_cs = 4'b1101; miso_inv = 1'b1;
        i_cs_sel = 2'd1; i_len = 6'd5; i_tx_data = 32'h0F0F_1234; i_tx_valid = 1'b1; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        wait_rxv(r0 + 2, 60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_word2: rx_valid not seen within 60 cycles"); end
        #1;
        repeat (5) @(posedge i_clk);
        #1;
        i_abort = 1'b1;
        @(negedge i_clk);
        checks++; if (o_SCLK !== 1'b1) begin errors++; $display("FAIL abort_in_high: sclk got %b exp 1", o_SCLK); end
        @(posedge i_clk); #1;
        i_abort = 1'b0;
        @(negedge i_clk);
        checks++; if (o_SCLK !== 1'b0) begin errors++; $display("FAIL abort_sclk_drop: got %b exp 0", o_SCLK); end
        checks++; if (o_tx_ready !== 1'b0) begin errors++; $display("FAIL abort_tail_ready: got %b exp 0", o_tx_ready); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL abort_tail_busy: got %b exp 1", o_busy); end
        wait_done(d0, 30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_timeout: o_done not seen within 30 cycles"); end
        checks++; if (rxv_cnt - r0 !== 2) begin errors++; $display("FAIL abort_rx_count: got %0d exp 2", rxv_cnt - r0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL abort_done_count: got %0d exp 1", done_cnt - d0); end
        checks++; if (cs_err_cnt - c0 !== 0) begin errors++; $display("FAIL abort_cs: got %0d bad cycles exp 0", cs_err_cnt - c0); end
        checks++; if (o_cs !== 4'hF) begin errors++; $display("FAIL abort_cs_released: got %b exp 1111", o_cs); end
        i_tx_valid = 1'b0;
    endtask

    task automatic test_abort_last_high;
        int r0, d0;
        bit ok;
        r0 = rxv_cnt; d0 = done_cnt;
        exp_cs = 4'b1011; miso_inv = 1'b1;
        i_cs_sel = 2'd2; i_len = 6'd3; i_tx_data = 32'h55AA_55AA; i_tx_valid = 1'b1;
        i_start = 1'b1; i_abort = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_abort = 1'b0;
        @(negedge i_clk);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL start_abort_busy: got %b exp 1", o_busy); end
        checks++; if (o_tx_ready !== 1'b1) begin errors++; $display("FAIL start_abort_load: got %b exp 1", o_tx_ready); end
        repeat (8) @(posedge i_clk);
        #1;
        i_abort = 1'b1;
        @(negedge i_clk);
        checks++; if (o_SCLK !== 1'b1) begin errors++; $display("FAIL lasthigh_sclk: got %b exp 1", o_SCLK); end
        @(posedge i_clk);
        @(negedge i_clk);
        checks++; if (o_rx_valid !== 1'b1) begin errors++; $display("FAIL lasthigh_rx_valid: got %b exp 1", o_rx_valid); end
        checks++; if (o_tx_ready !== 1'b0) begin errors++; $display("FAIL lasthigh_to_tail: tx_ready got %b exp 0", o_tx_ready); end
        checks++; if (o_rx_data !== 32'hAA55_AA55) begin errors++; $display("FAIL lasthigh_rx_data: got %h exp aa55aa55", o_rx_data); end
        wait_done(d0, 30, ok);
        i_abort = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL lasthigh_timeout: o_done not seen within 30 cycles"); end
        checks++; if (rxv_cnt - r0 !== 1) begin errors++; $display("FAIL lasthigh_rx_count: got %0d exp 1", rxv_cnt - r0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL lasthigh_done_count: got %0d exp 1", done_cnt - d0); end
        checks++; if (last_done_cyc - last_hs_cyc !== 14) begin errors++; $display("FAIL lasthigh_done_time: got %0d exp 14", last_done_cyc - last_hs_cyc); end
        i_tx_valid = 1'b0;
    endtask

    task automatic test_len_zero;
        int r0, d0, c0, s0;
        bit ok;
        r0 = rxv_cnt; d0 = done_cnt; c0 = cs_err_cnt; s0 = sclk_rise_cnt;
        exp_cs = 4'b1101; miso_inv = 1'b0; miso_const = 32'hCAFE_F00D;
        i_cs_sel = 2'd1; i_len = 6'd0; i_tx_data = 32'h0000_0001; i_tx_valid = 1'b1; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_start = 1'b1; i_cs_sel = 2'd3; i_len = 6'd5;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        wait_done(d0, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL len0_timeout: o_done not seen within 40 cycles"); end
        checks++; if (rxv_cnt - r0 !== 1) begin errors++; $display("FAIL len0_rx_count: got %0d exp 1", rxv_cnt - r0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL len0_done_count: got %0d exp 1", done_cnt - d0); end
        checks++; if (sclk_rise_cnt - s0 !== 1) begin errors++; $display("FAIL len0_sclk_strobes: got %0d exp 1", sclk_rise_cnt - s0); end
        checks++; if (cs_err_cnt - c0 !== 0) begin errors++; $display("FAIL len0_cs: got %0d bad cycles exp 0", cs_err_cnt - c0); end
        checks++; if (o_rx_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL len0_rx_data: got %h exp cafef00d", o_rx_data); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL len0_idle_after: busy got %b exp 0", o_busy); end
        i_tx_valid = 1'b0;
    endtask

    task automatic test_reset_mid_burst;
        int r0, d0;
        bit ok;
        d0 = done_cnt;
        exp_cs = 4'b1110; miso_inv = 1'b1;
        i_cs_sel = 2'd0; i_len = 6'd2; i_tx_data = 32'h7777_8888; i_tx_valid = 1'b1; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(posedge i_clk); #2;
        i_rst = 1'b0;
        #1;
        checks++; if (o_cs !== 4'hF) begin errors++; $display("FAIL rstmid_cs: got %b exp 1111", o_cs); end
        checks++; if (o_SCLK !== 1'b0) begin errors++; $display("FAIL rstmid_sclk: got %b exp 0", o_SCLK); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b exp 0", o_busy); end
        checks++; if (o_MOSI !== '0) begin errors++; $display("FAIL rstmid_mosi: got %h exp 0", o_MOSI); end
        checks++; if (o_rx_data !== '0) begin errors++; $display("FAIL rstmid_rx_data: got %h exp 0", o_rx_data); end
        checks++; if (o_tx_ready !== 1'b0) begin errors++; $display("FAIL rstmid_tx_ready: got %b exp 0", o_tx_ready); end
        repeat (3) @(posedge i_clk);
        #1;
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d exp 0", done_cnt - d0); end
        r0 = rxv_cnt; d0 = done_cnt;
        i_rst = 1'b1; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(negedge i_clk);
        checks++; if (o_tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_first_edge_start: tx_ready got %b exp 1", o_tx_ready); end
        wait_done(d0, 60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout: o_done not seen within 60 cycles"); end
        checks++; if (rxv_cnt - r0 !== 2) begin errors++; $display("FAIL rstmid_rx_count: got %0d exp 2", rxv_cnt - r0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rstmid_done_count: got %0d exp 1", done_cnt - d0); end
        checks++; if (o_rx_data !== 32'h8888_7777) begin errors++; $display("FAIL rstmid_rx_data: got %h exp 88887777", o_rx_data); end
        i_tx_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_burst();
        test_stall();
        test_abort();
        test_abort_last_high();
        test_len_zero();
        test_reset_mid_burst();
        repeat (3) @(posedge i_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_master_parallel.md
SPI_MASTER_PARALLEL -- requirements
Module: spi_master_parallel

Interface
REQ-001 SHALL have parameter NB_BITS, default 32, the data word width.
REQ-002 SHALL have parameter NB_CS, default 4, the number of slave chip-selects.
REQ-003 SHALL have parameter CLK_DIV, default 4 (legal range >=1), the i_clk cycles per SCLK half-period.
REQ-004 SHALL have parameter NB_LEN, default 6, the burst-length width.
REQ-005 SHALL have ports, in this order:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_start  in  1  start a burst; sampled only in IDLE.
- i_cs_sel  in  $clog2(NB_CS)  target slave index.
- i_len  in  NB_LEN  words in the burst; 0 is treated as 1.
- i_abort  in  1  terminate the burst early.
- i_tx_data  in  NB_BITS  word to transmit.
- i_tx_valid  in  1  i_tx_data is valid.
- o_tx_ready  out  1  master accepts i_tx_data this cycle.
- o_rx_data  out  NB_BITS  last word received.
- o_rx_valid  out  1  one-cycle pulse: o_rx_data has been updated.
- o_busy  out  1  a burst is in progress.
- o_done  out  1  one-cycle pulse: the burst has ended.
- o_MOSI  out  NB_BITS  parallel word driven to the slave.
- o_SCLK  out  1  slave strobe.
- o_cs  out  NB_CS  chip-selects, active-low, at most one low at a time.
- i_MISO  in  NB_BITS  parallel word returned by the slave.

Function
REQ-006 SHALL implement a state machine with states IDLE, LOAD, SETUP, HIGH and TAIL.
REQ-007 In IDLE, when i_start=1: SHALL latch i_cs_sel and max(i_len,1) into a remaining-word counter, and move to LOAD on the next edge.
REQ-008 SHALL hold o_cs[sel]=0 in LOAD, SETUP and HIGH, and during TAIL; all other o_cs bits SHALL be 1.
REQ-009 LOAD:
- o_tx_ready=1.
- On i_tx_valid=1, SHALL register i_tx_data into o_MOSI and go to SETUP.
- Otherwise SHALL wait indefinitely with SCLK=0 and CS held low.
REQ-010 SETUP: SHALL hold o_SCLK=0 for exactly CLK_DIV cycles, then go to HIGH.
REQ-011 HIGH: SHALL hold o_SCLK=1 for exactly CLK_DIV cycles.
REQ-012 On the last HIGH cycle, SHALL register i_MISO into o_rx_data and decrement the counter; o_rx_valid SHALL be 1 in the following cycle only.
REQ-013 After HIGH: SHALL go to LOAD if the counter is nonzero, else to TAIL.
REQ-014 Per-word minimum latency, from tx handshake to o_rx_valid, SHALL be 2*CLK_DIV+1 cycles.
REQ-015 o_MOSI SHALL remain stable from SETUP entry until the next tx handshake, and SHALL be 0 in IDLE.
REQ-016 TAIL: SHALL hold o_SCLK=0 and CS low for CLK_DIV cycles, then deassert all CS, pulse o_done for one cycle and return to IDLE.
REQ-017 o_busy SHALL be 1 in every state except IDLE.
REQ-018 i_start while o_busy=1 SHALL be ignored; i_cs_sel and i_len changes mid-burst SHALL have no effect.
REQ-019 i_abort=1 in LOAD, SETUP or HIGH SHALL go to TAIL on the next edge.
REQ-020 On abort: o_SCLK SHALL drop to 0, no o_rx_valid SHALL be issued for the incomplete word, and o_done SHALL pulse as for normal completion.
REQ-021 i_abort in IDLE or TAIL SHALL be ignored.
REQ-022 If i_abort and the last HIGH cycle coincide, the word SHALL complete (o_rx_valid pulses) and the FSM SHALL go to TAIL.
REQ-023 A simultaneous i_start and i_abort in IDLE SHALL start a burst.
REQ-024 o_rx_data SHALL hold its value until the next capture; it is not cleared between bursts.

Reset
REQ-025 i_rst=0 SHALL asynchronously force:
- state IDLE;
- o_cs all ones, o_SCLK=0, o_MOSI=0, o_rx_data=0;
- o_rx_valid=0, o_done=0, o_busy=0, o_tx_ready=0;
- counter 0.
REQ-026 Reset asserted mid-burst SHALL abandon the burst with no o_done pulse; CS SHALL rise immediately (asynchronously).
REQ-027 After reset deassertion, the block SHALL accept i_start on the first rising edge.

Verification
REQ-028 Single word: CLK_DIV=4, sel=2, len=1, tx=0xDEADBEEF, slave MISO=0x12345678.
- o_cs=4'b1011 for the whole burst; o_SCLK low 4 cycles, then high 4 cycles.
- o_rx_data=0x12345678 with o_rx_valid 9 cycles after the handshake.
- o_done pulses 5 cycles later.
REQ-029 Burst: len=32, tx always valid. Exactly 32 o_rx_valid pulses, 9 cycles apart; CS never rises between words; one o_done.
REQ-030 Stall: i_tx_valid withheld 10 cycles before word 2. The FSM holds LOAD with SCLK=0 and CS low; no extra strobe; the burst completes normally.
REQ-031 Abort in the 2nd HIGH cycle of word 3 of len=5. SCLK falls the next cycle; exactly 2 o_rx_valid pulses; o_done once; CS released after TAIL.
REQ-032 Reset mid-SETUP of word 1: o_cs=all ones and o_SCLK=0 within the reset-assertion cycle with no clock edge; no o_done; a new i_start after release runs a correct burst.
REQ-033 len=0 behaves as len=1; i_start pulsed mid-burst changes nothing.
